// File: rtl/retire_pair_aligner.sv
`default_nettype none
// ============================================================================
// Module      : retire_pair_aligner
// Description : Buffers commit records from two lock-step cores and retires
//               them as aligned pairs. Optional RETIRE_ALIGN_PAIR_COUNT_EN
//               enables the retired-pair counter.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_pair_aligner #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        commit_valid_1_i,
  output logic        commit_ready_1_o,
  input  logic [31:0] instr_1_i,
  input  logic [31:0] reg_rs1_1_i,
  input  logic [31:0] reg_rs2_1_i,
  input  logic [31:0] reg_rd_1_i,
  input  logic [31:0] mem_addr_1_i,
  input  logic [31:0] mem_r_data_1_i,
  input  logic [31:0] mem_w_data_1_i,
  input  logic        commit_valid_2_i,
  output logic        commit_ready_2_o,
  input  logic [31:0] instr_2_i,
  input  logic [31:0] reg_rs1_2_i,
  input  logic [31:0] reg_rs2_2_i,
  input  logic [31:0] reg_rd_2_i,
  input  logic [31:0] mem_addr_2_i,
  input  logic [31:0] mem_r_data_2_i,
  input  logic [31:0] mem_w_data_2_i,
  output logic        retire_o,
  output logic [31:0] instr_1_o,
  output logic [31:0] reg_rs1_1_o,
  output logic [31:0] reg_rs2_1_o,
  output logic [31:0] reg_rd_1_o,
  output logic [31:0] mem_addr_1_o,
  output logic [31:0] mem_r_data_1_o,
  output logic [31:0] mem_w_data_1_o,
  output logic [31:0] instr_2_o,
  output logic [31:0] reg_rs1_2_o,
  output logic [31:0] reg_rs2_2_o,
  output logic [31:0] reg_rd_2_o,
  output logic [31:0] mem_addr_2_o,
  output logic [31:0] mem_r_data_2_o,
  output logic [31:0] mem_w_data_2_o,
  output logic        diverged_o,
  output logic [31:0] pair_count_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_SW = $clog2(TIMEOUT + 1);
  localparam int c_EW = 224;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_SW-1:0]     r_skew, w_skew_nxt;
  logic [1:0][c_EW-1:0] w_din, w_head, r_out;
  logic [1:0]          w_valid, w_ready, w_push, w_full, w_nonempty;
  logic                w_pop, w_skew_cond, r_retire;

  assign w_din[0] = {instr_1_i, reg_rs1_1_i, reg_rs2_1_i, reg_rd_1_i,
                     mem_addr_1_i, mem_r_data_1_i, mem_w_data_1_i};
  assign w_din[1] = {instr_2_i, reg_rs1_2_i, reg_rs2_2_i, reg_rd_2_i,
                     mem_addr_2_i, mem_r_data_2_i, mem_w_data_2_i};
  assign w_valid  = {commit_valid_2_i, commit_valid_1_i};

  // Pop decision uses registered occupancy only, giving the fixed 2-edge latency.
  assign w_pop = (r_state == ST_RUN) && w_nonempty[0] && w_nonempty[1];

  generate
    for (genvar k = 0; k < 2; k++) begin : g_fifo
      logic [c_EW-1:0] r_mem [DEPTH];
      logic [c_AW-1:0] r_wptr, r_rptr;
      logic [c_CW-1:0] r_count;

      assign w_full[k]     = (r_count == c_CW'(DEPTH));
      assign w_nonempty[k] = (r_count != '0);
      assign w_ready[k]    = !rst_i && (r_state == ST_RUN) && !w_full[k];
      assign w_push[k]     = w_valid[k] && w_ready[k];
      assign w_head[k]     = r_mem[r_rptr];

      always_ff @(posedge clk_i) begin
        if (w_push[k]) begin
          r_mem[r_wptr] <= w_din[k];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[k]) r_wptr <= r_wptr + c_AW'(1);
          if (w_pop)     r_rptr <= r_rptr + c_AW'(1);
          r_count <= r_count + c_CW'(w_push[k]) - c_CW'(w_pop);
        end
      end
    end
  endgenerate

  assign commit_ready_1_o = w_ready[0];
  assign commit_ready_2_o = w_ready[1];

  // One run full while the other is empty counts as skew.
  assign w_skew_cond = (w_full[0] && !w_nonempty[1]) || (w_full[1] && !w_nonempty[0]);

  always_comb begin
    w_state_nxt = r_state;
    w_skew_nxt  = '0;
    if (r_state == ST_HALT) begin
      w_skew_nxt = r_skew;
    end else if (w_skew_cond) begin
      w_skew_nxt = r_skew + c_SW'(1);
      if (w_skew_nxt == c_SW'(TIMEOUT)) w_state_nxt = ST_HALT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_RUN;
      r_skew   <= '0;
      r_retire <= 1'b0;
      r_out    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_skew   <= w_skew_nxt;
      r_retire <= w_pop;
      if (w_pop) r_out <= w_head;
    end
  end

  assign retire_o   = r_retire;
  assign diverged_o = (r_state == ST_HALT);
  assign {instr_1_o, reg_rs1_1_o, reg_rs2_1_o, reg_rd_1_o,
          mem_addr_1_o, mem_r_data_1_o, mem_w_data_1_o} = r_out[0];
  assign {instr_2_o, reg_rs1_2_o, reg_rs2_2_o, reg_rd_2_o,
          mem_addr_2_o, mem_r_data_2_o, mem_w_data_2_o} = r_out[1];

`ifdef RETIRE_ALIGN_PAIR_COUNT_EN
  logic [31:0] r_pair_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pair_count <= '0;
    end else if (w_pop && (r_pair_count != 32'hFFFF_FFFF)) begin
      r_pair_count <= r_pair_count + 32'd1;
    end
  end

  assign pair_count_o = r_pair_count;
`else
  assign pair_count_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_retire_pair_aligner.sv
`default_nettype none
// Self-checking bench for retire_pair_aligner: vector table plus directed
// full/divergence/reset sequences and a random-skew scoreboard.
module tb_retire_pair_aligner;

`ifdef RETIRE_ALIGN_PAIR_COUNT_EN
  localparam bit c_PC_ON = 1'b1;
`else
  localparam bit c_PC_ON = 1'b0;
`endif
  localparam logic [31:0] c_X = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0, rst_i;
  logic        commit_valid_1_i, commit_ready_1_o, commit_valid_2_i, commit_ready_2_o;
  logic [31:0] instr_1_i, reg_rs1_1_i, reg_rs2_1_i, reg_rd_1_i;
  logic [31:0] mem_addr_1_i, mem_r_data_1_i, mem_w_data_1_i;
  logic [31:0] instr_2_i, reg_rs1_2_i, reg_rs2_2_i, reg_rd_2_i;
  logic [31:0] mem_addr_2_i, mem_r_data_2_i, mem_w_data_2_i;
  logic        retire_o, diverged_o;
  logic [31:0] instr_1_o, reg_rs1_1_o, reg_rs2_1_o, reg_rd_1_o;
  logic [31:0] mem_addr_1_o, mem_r_data_1_o, mem_w_data_1_o;
  logic [31:0] instr_2_o, reg_rs1_2_o, reg_rs2_2_o, reg_rd_2_o;
  logic [31:0] mem_addr_2_o, mem_r_data_2_o, mem_w_data_2_o;
  logic [31:0] pair_count_o;
  logic [223:0] w_o1, w_o2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  retire_pair_aligner #(.DEPTH(8), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .commit_valid_1_i(commit_valid_1_i), .commit_ready_1_o(commit_ready_1_o),
    .instr_1_i(instr_1_i), .reg_rs1_1_i(reg_rs1_1_i), .reg_rs2_1_i(reg_rs2_1_i),
    .reg_rd_1_i(reg_rd_1_i), .mem_addr_1_i(mem_addr_1_i), .mem_r_data_1_i(mem_r_data_1_i),
    .mem_w_data_1_i(mem_w_data_1_i),
    .commit_valid_2_i(commit_valid_2_i), .commit_ready_2_o(commit_ready_2_o),
    .instr_2_i(instr_2_i), .reg_rs1_2_i(reg_rs1_2_i), .reg_rs2_2_i(reg_rs2_2_i),
    .reg_rd_2_i(reg_rd_2_i), .mem_addr_2_i(mem_addr_2_i), .mem_r_data_2_i(mem_r_data_2_i),
    .mem_w_data_2_i(mem_w_data_2_i),
    .retire_o(retire_o),
    .instr_1_o(instr_1_o), .reg_rs1_1_o(reg_rs1_1_o), .reg_rs2_1_o(reg_rs2_1_o),
    .reg_rd_1_o(reg_rd_1_o), .mem_addr_1_o(mem_addr_1_o), .mem_r_data_1_o(mem_r_data_1_o),
    .mem_w_data_1_o(mem_w_data_1_o),
    .instr_2_o(instr_2_o), .reg_rs1_2_o(reg_rs1_2_o), .reg_rs2_2_o(reg_rs2_2_o),
    .reg_rd_2_o(reg_rd_2_o), .mem_addr_2_o(mem_addr_2_o), .mem_r_data_2_o(mem_r_data_2_o),
    .mem_w_data_2_o(mem_w_data_2_o),
    .diverged_o(diverged_o), .pair_count_o(pair_count_o)
  );

  assign w_o1 = {instr_1_o, reg_rs1_1_o, reg_rs2_1_o, reg_rd_1_o, mem_addr_1_o, mem_r_data_1_o, mem_w_data_1_o};
  assign w_o2 = {instr_2_o, reg_rs1_2_o, reg_rs2_2_o, reg_rd_2_o, mem_addr_2_o, mem_r_data_2_o, mem_w_data_2_o};

  typedef struct {
    logic        v1, v2;
    logic [31:0] in1, in2;
    logic        rdy1, rdy2;
    logic        ret;
    logic [31:0] out1, out2;
  } vec_t;

  vec_t vecs [23];

  // Full 224-bit record derived from the instruction word.
  function automatic logic [223:0] rec(input logic [31:0] ins);
    return {ins, ins ^ 32'h1111_1111, ins + 32'h22, ins ^ 32'h3300_0000,
            ins + 32'h4000, ins ^ 32'h0000_5555, ~ins};
  endfunction

  function automatic logic [223:0] expo(input logic [31:0] ins);
    return (ins == 32'd0) ? 224'd0 : rec(ins);
  endfunction

  function automatic vec_t mk(input logic v1, input logic [31:0] in1, input logic v2,
                              input logic [31:0] in2, input logic ret,
                              input logic [31:0] o1, input logic [31:0] o2);
    vec_t v;
    v.v1 = v1; v.in1 = in1; v.v2 = v2; v.in2 = in2;
    v.rdy1 = 1'b1; v.rdy2 = 1'b1; v.ret = ret; v.out1 = o1; v.out2 = o2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set1(input logic v, input logic [31:0] ins);
    commit_valid_1_i = v;
    {instr_1_i, reg_rs1_1_i, reg_rs2_1_i, reg_rd_1_i, mem_addr_1_i, mem_r_data_1_i, mem_w_data_1_i} = rec(ins);
  endtask

  task automatic set2(input logic v, input logic [31:0] ins);
    commit_valid_2_i = v;
    {instr_2_i, reg_rs1_2_i, reg_rs2_2_i, reg_rd_2_i, mem_addr_2_i, mem_r_data_2_i, mem_w_data_2_i} = rec(ins);
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    set1(1'b0, c_X);
    set2(1'b0, c_X);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] q1[$], q2[$];
    logic [31:0] e1, e2;
    int m1, m2, s1, s2, popped, exp_pops;
    logic v1, v2, pop, push1, push2;

    vecs[0]  = mk(1, 32'h100, 1, 32'h100, 0, 32'h0,   32'h0);
    vecs[1]  = mk(1, 32'h101, 1, 32'h101, 1, 32'h100, 32'h100);
    vecs[2]  = mk(1, 32'h102, 1, 32'h102, 1, 32'h101, 32'h101);
    vecs[3]  = mk(1, 32'h103, 1, 32'h103, 1, 32'h102, 32'h102);
    vecs[4]  = mk(1, 32'h104, 1, 32'h104, 1, 32'h103, 32'h103);
    vecs[5]  = mk(1, 32'h105, 1, 32'h105, 1, 32'h104, 32'h104);
    vecs[6]  = mk(1, 32'h106, 1, 32'h106, 1, 32'h105, 32'h105);
    vecs[7]  = mk(1, 32'h107, 1, 32'h107, 1, 32'h106, 32'h106);
    vecs[8]  = mk(1, 32'h108, 1, 32'h108, 1, 32'h107, 32'h107);
    vecs[9]  = mk(1, 32'h109, 1, 32'h109, 1, 32'h108, 32'h108);
    vecs[10] = mk(0, c_X,     0, c_X,     1, 32'h109, 32'h109);
    vecs[11] = mk(0, c_X,     0, c_X,     0, 32'h109, 32'h109);
    vecs[12] = mk(1, 32'h200, 0, c_X,     0, 32'h109, 32'h109);
    vecs[13] = mk(1, 32'h201, 0, c_X,     0, 32'h109, 32'h109);
    vecs[14] = mk(1, 32'h202, 0, c_X,     0, 32'h109, 32'h109);
    vecs[15] = mk(1, 32'h203, 0, c_X,     0, 32'h109, 32'h109);
    vecs[16] = mk(1, 32'h204, 1, 32'h200, 0, 32'h109, 32'h109);
    vecs[17] = mk(0, c_X,     1, 32'h201, 1, 32'h200, 32'h200);
    vecs[18] = mk(0, c_X,     1, 32'h202, 1, 32'h201, 32'h201);
    vecs[19] = mk(0, c_X,     1, 32'h203, 1, 32'h202, 32'h202);
    vecs[20] = mk(0, c_X,     1, 32'h204, 1, 32'h203, 32'h203);
    vecs[21] = mk(0, c_X,     0, c_X,     1, 32'h204, 32'h204);
    vecs[22] = mk(0, c_X,     0, c_X,     0, 32'h204, 32'h204);

    // Reset state
    rst_i = 1'b1;
    set1(1'b1, c_X);
    set2(1'b1, c_X);
    @(negedge clk_i);
    #1;
    chk("rst_ready1_low", 224'(commit_ready_1_o), 224'd0);
    chk("rst_ready2_low", 224'(commit_ready_2_o), 224'd0);
    tick();
    set1(1'b0, c_X);
    set2(1'b0, c_X);
    rst_i = 1'b0;
    #1;
    chk("rst_retire", 224'(retire_o), 224'd0);
    chk("rst_out1", w_o1, 224'd0);
    chk("rst_out2", w_o2, 224'd0);
    chk("rst_diverged", 224'(diverged_o), 224'd0);
    chk("rst_pair_count", 224'(pair_count_o), 224'd0);
    chk("rst_ready1_high", 224'(commit_ready_1_o), 224'd1);

    // Lock-step and skew vectors
    exp_pops = 0;
    for (int i = 0; i < 23; i++) begin
      set1(vecs[i].v1, vecs[i].in1);
      set2(vecs[i].v2, vecs[i].in2);
      #1;
      chk($sformatf("vec%0d_ready1", i), 224'(commit_ready_1_o), 224'(vecs[i].rdy1));
      chk($sformatf("vec%0d_ready2", i), 224'(commit_ready_2_o), 224'(vecs[i].rdy2));
      tick();
      if (vecs[i].ret) exp_pops++;
      chk($sformatf("vec%0d_retire", i), 224'(retire_o), 224'(vecs[i].ret));
      chk($sformatf("vec%0d_out1", i), w_o1, expo(vecs[i].out1));
      chk($sformatf("vec%0d_out2", i), w_o2, expo(vecs[i].out2));
    end
    chk("table_pair_count", 224'(pair_count_o), c_PC_ON ? 224'(exp_pops) : 224'd0);
    chk("table_diverged", 224'(diverged_o), 224'd0);

    // Full FIFO on run 1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set1(1'b1, 32'h300 + i);
      #1;
      chk($sformatf("full_ready1_%0d", i), 224'(commit_ready_1_o), 224'd1);
      tick();
    end
    #1;
    chk("full_ready1_low", 224'(commit_ready_1_o), 224'd0);
    set1(1'b1, 32'h3FF);
    set2(1'b1, 32'h300);
    tick();
    chk("full_no_pop_yet", 224'(retire_o), 224'd0);
    set2(1'b0, c_X);
    tick();
    chk("full_pop_retire", 224'(retire_o), 224'd1);
    chk("full_pop_out1", w_o1, rec(32'h300));
    chk("full_pop_out2", w_o2, rec(32'h300));
    #1;
    chk("full_ready1_again", 224'(commit_ready_1_o), 224'd1);
    set1(1'b0, c_X);
    for (int j = 1; j < 8; j++) begin
      set2(1'b1, 32'h300 + j);
      tick();
      if (j >= 2) chk($sformatf("full_drain_%0d", j), w_o1, rec(32'h300 + j - 1));
    end
    set2(1'b0, c_X);
    tick();
    chk("full_last_retire", 224'(retire_o), 224'd1);
    chk("full_last_out1", w_o1, rec(32'h307));
    tick();
    chk("full_no_extra", 224'(retire_o), 224'd0);

    // Divergence
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set1(1'b1, 32'h400 + i);
      tick();
    end
    set1(1'b0, c_X);
    repeat (63) tick();
    chk("div_not_yet", 224'(diverged_o), 224'd0);
    tick();
    chk("div_set", 224'(diverged_o), 224'd1);
    #1;
    chk("div_ready1", 224'(commit_ready_1_o), 224'd0);
    chk("div_ready2", 224'(commit_ready_2_o), 224'd0);
    set2(1'b1, 32'h400);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("div_no_retire_%0d", i), 224'(retire_o), 224'd0);
    end
    chk("div_sticky", 224'(diverged_o), 224'd1);

    // Reset mid-stream
    do_reset();
    set1(1'b1, 32'h600);
    set2(1'b1, 32'h600);
    tick();
    set2(1'b0, c_X);
    for (int i = 1; i < 4; i++) begin
      set1(1'b1, 32'h600 + i);
      tick();
    end
    chk("mid_pre_out1", w_o1, rec(32'h600));
    rst_i = 1'b1;
    set1(1'b1, 32'h6AA);
    set2(1'b1, 32'h6AA);
    #1;
    chk("mid_rst_ready1", 224'(commit_ready_1_o), 224'd0);
    tick();
    chk("mid_rst_retire", 224'(retire_o), 224'd0);
    chk("mid_rst_out1", w_o1, 224'd0);
    chk("mid_rst_out2", w_o2, 224'd0);
    chk("mid_rst_pair_count", 224'(pair_count_o), 224'd0);
    rst_i = 1'b0;
    set1(1'b0, c_X);
    set2(1'b0, c_X);
    tick();
    chk("mid_idle_retire", 224'(retire_o), 224'd0);
    set1(1'b1, 32'h700);
    set2(1'b1, 32'h700);
    tick();
    set1(1'b0, c_X);
    set2(1'b0, c_X);
    chk("mid_fresh_wait", 224'(retire_o), 224'd0);
    tick();
    chk("mid_fresh_retire", 224'(retire_o), 224'd1);
    chk("mid_fresh_out1", w_o1, rec(32'h700));
    chk("mid_fresh_out2", w_o2, rec(32'h700));

    // Random-skew scoreboard, run 1 biased to sit at full
    do_reset();
    m1 = 0; m2 = 0; s1 = 0; s2 = 0; popped = 0;
    for (int cyc = 0; cyc < 4000 && popped < 200; cyc++) begin
      v1 = (s1 < 200) && ($urandom_range(9) != 0);
      v2 = (s2 < 200) && ($urandom_range(1) != 0);
      set1(v1, 32'h1000 + s1);
      set2(v2, 32'h1000 + s2);
      #1;
      chk("sb_ready1", 224'(commit_ready_1_o), 224'(m1 != 8));
      chk("sb_ready2", 224'(commit_ready_2_o), 224'(m2 != 8));
      pop   = (m1 != 0) && (m2 != 0);
      push1 = v1 && (m1 != 8);
      push2 = v2 && (m2 != 8);
      tick();
      chk("sb_retire", 224'(retire_o), 224'(pop));
      if (pop) begin
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        chk("sb_out1", w_o1, rec(e1));
        chk("sb_out2", w_o2, rec(e2));
        popped++;
      end
      if (push1) begin q1.push_back(32'h1000 + s1); s1++; end
      if (push2) begin q2.push_back(32'h1000 + s2); s2++; end
      m1 = m1 + int'(push1) - int'(pop);
      m2 = m2 + int'(push2) - int'(pop);
    end
    n_checks++;
    if (popped != 200) begin
      n_errors++;
      $display("FAIL sb_completion actual=%0d required=200", popped);
    end
    chk("sb_diverged", 224'(diverged_o), 224'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
